// File: rtl/mem_dp_burst_ctl_pkg.sv
// Shared types and constants for the dual-port memory burst initiator.
package mem_dp_burst_ctl_pkg;
   localparam int unsigned MEM_DEPTH = 512;
   localparam int unsigned ADR_W     = 9;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned LEN_W     = 4;
   localparam int unsigned BE_W      = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_CLEAR = 2'd3
   } state_e;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } rsp_t;
endpackage

// File: rtl/mem_dp_rsp_buf.sv
// Two-entry response FIFO holding {last, data}; occupancy feeds the read credit check.
module mem_dp_rsp_buf
   import mem_dp_burst_ctl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  rsp_t       i_push_entry,
   input  logic       i_pop,
   output rsp_t       o_head,
   output logic       o_valid,
   output logic [1:0] o_occ
);
   rsp_t       ent_q [2];
   rsp_t       ent_d [2];
   logic       wptr_q, wptr_d;
   logic       rptr_q, rptr_d;
   logic [1:0] occ_q, occ_d;
   logic       pop_ok;

   assign pop_ok = i_pop && (occ_q != 2'd0);

   always_comb begin
      ent_d[0] = ent_q[0];
      ent_d[1] = ent_q[1];
      wptr_d   = wptr_q ^ i_push;
      rptr_d   = rptr_q ^ pop_ok;
      occ_d    = occ_q + 2'(i_push) - 2'(pop_ok);
      if (i_push) ent_d[wptr_q] = i_push_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) ent_q[i] <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         occ_q  <= 2'd0;
      end else begin
         for (int i = 0; i < 2; i++) ent_q[i] <= ent_d[i];
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
      end
   end

   assign o_head  = ent_q[rptr_q];
   assign o_valid = (occ_q != 2'd0);
   assign o_occ   = occ_q;
endmodule

// File: rtl/mem_dp_burst_ctl.sv
// Burst read/write/clear initiator for one port of the 512x32 byte-enabled memory.
module mem_dp_burst_ctl
   import mem_dp_burst_ctl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_wr,
   input  logic [ADR_W-1:0]  i_req_adr,
   input  logic [LEN_W-1:0]  i_req_len,
   input  logic [BE_W-1:0]   i_req_be,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_rd_valid,
   input  logic              i_rd_ready,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_last,
   output logic              o_busy,
   output logic              o_mem_en,
   output logic [BE_W-1:0]   o_mem_wen,
   output logic [ADR_W-1:0]  o_mem_adr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);
   state_e             state_q, state_d;
   logic [ADR_W-1:0]   adr_q, adr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [BE_W-1:0]    be_q, be_d;
   logic               infl_q, infl_d;
   logic               infl_last_q, infl_last_d;
   logic [1:0]         occ;
   logic [2:0]         used_c;
   logic               rd_pop;
   logic               rd_issue;
   rsp_t               head;

   // A pop this cycle frees its slot, which keeps reads at one beat per cycle.
   assign rd_pop   = o_rd_valid && i_rd_ready;
   assign used_c   = 3'(occ) + 3'(infl_q) - 3'(rd_pop);
   assign rd_issue = (state_q == ST_READ) && (used_c < 3'd2);

   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      rem_d       = rem_q;
      be_d        = be_q;
      infl_d      = rd_issue;
      infl_last_d = rd_issue && (rem_q == '0);
      o_mem_en    = 1'b0;
      o_mem_wen   = '0;
      o_mem_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (i_clr) begin
               state_d = ST_CLEAR;
               adr_d   = '0;
            end else if (i_req_valid) begin
               adr_d   = i_req_adr;
               rem_d   = i_req_len;
               be_d    = i_req_be;
               state_d = i_req_wr ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            if (i_wr_valid) begin
               o_mem_en    = 1'b1;
               o_mem_wen   = be_q;
               o_mem_wdata = i_wr_data;
               adr_d       = adr_q + ADR_W'(1);
               rem_d       = rem_q - LEN_W'(1);
               if (rem_q == '0) state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (rd_issue) begin
               o_mem_en = 1'b1;
               adr_d    = adr_q + ADR_W'(1);
               rem_d    = rem_q - LEN_W'(1);
               if (rem_q == '0) state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            o_mem_en  = 1'b1;
            o_mem_wen = '1;
            adr_d     = adr_q + ADR_W'(1);
            if (adr_q == ADR_W'(MEM_DEPTH - 1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         adr_q       <= '0;
         rem_q       <= '0;
         be_q        <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         adr_q       <= adr_d;
         rem_q       <= rem_d;
         be_q        <= be_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
      end
   end

   mem_dp_rsp_buf u_rsp_buf (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (infl_q),
      .i_push_entry ('{last: infl_last_q, data: i_mem_rdata}),
      .i_pop        (rd_pop),
      .o_head       (head),
      .o_valid      (o_rd_valid),
      .o_occ        (occ)
   );

   assign o_rd_data   = head.data;
   assign o_rd_last   = head.last;
   assign o_req_ready = (state_q == ST_IDLE) && !i_clr;
   assign o_wr_ready  = (state_q == ST_WRITE);
   assign o_busy      = (state_q != ST_IDLE) || infl_q || (occ != 2'd0);
   assign o_mem_adr   = adr_q;
endmodule

// File: tb/tb_mem_dp_burst_ctl.sv
// Scoreboard bench: a word-level memory image predicts every memory write and read response.
module tb_mem_dp_burst_ctl;
   import mem_dp_burst_ctl_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_clr = 1'b0;
   logic              i_req_valid = 1'b0;
   logic              o_req_ready;
   logic              i_req_wr = 1'b0;
   logic [8:0]        i_req_adr = '0;
   logic [3:0]        i_req_len = '0;
   logic [3:0]        i_req_be = '0;
   logic              i_wr_valid = 1'b0;
   logic              o_wr_ready;
   logic [31:0]       i_wr_data = '0;
   logic              o_rd_valid;
   logic              i_rd_ready = 1'b1;
   logic [31:0]       o_rd_data;
   logic              o_rd_last;
   logic              o_busy;
   logic              o_mem_en;
   logic [3:0]        o_mem_wen;
   logic [8:0]        o_mem_adr;
   logic [31:0]       o_mem_wdata;
   logic [31:0]       i_mem_rdata = '0;

   mem_dp_burst_ctl dut (
      .clk(clk), .rst_n(rst_n), .i_clr(i_clr),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
      .i_req_adr(i_req_adr), .i_req_len(i_req_len), .i_req_be(i_req_be),
      .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
      .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
      .o_rd_last(o_rd_last), .o_busy(o_busy), .o_mem_en(o_mem_en),
      .o_mem_wen(o_mem_wen), .o_mem_adr(o_mem_adr), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { logic [8:0] adr; logic [3:0] wen; logic [31:0] data; } wr_exp_t;
   typedef struct { logic [31:0] data; logic last; } rd_exp_t;

   logic [31:0] mem_arr [512];
   logic [31:0] ref_mem [512];
   logic [31:0] mw;
   wr_exp_t     wq [$];
   rd_exp_t     rq [$];
   wr_exp_t     mon_w;
   rd_exp_t     mon_r;
   int          total = 0;
   int          bad = 0;
   int          rd_issues = 0;
   bit          rd_rand = 1'b0;
   bit          rd_force = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic report_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=no-event required=event", name);
   endtask

   // Memory port behind the DUT: byte-enabled writes, 1-cycle read latency.
   always @(posedge clk) begin
      if (o_mem_en) begin
         if (o_mem_wen == 4'h0) i_mem_rdata <= mem_arr[o_mem_adr];
         else begin
            mw = mem_arr[o_mem_adr];
            for (int b = 0; b < 4; b++)
               if (o_mem_wen[b]) mw[b*8 +: 8] = o_mem_wdata[b*8 +: 8];
            mem_arr[o_mem_adr] <= mw;
         end
      end
   end

   // Read-ready pattern: forced level or random back-pressure.
   initial forever begin
      @(posedge clk);
      #1;
      i_rd_ready = rd_rand ? ($urandom_range(0, 2) != 0) : rd_force;
   end

   // Monitor: compares memory writes and read responses with the scoreboard queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_mem_en && o_mem_wen == 4'h0) rd_issues++;
         if (o_mem_en && o_mem_wen != 4'h0) begin
            if (wq.size() == 0) report_fail("mem_wr_unexpected");
            else begin
               mon_w = wq.pop_front();
               check("mem_adr", 64'(o_mem_adr), 64'(mon_w.adr));
               check("mem_wen", 64'(o_mem_wen), 64'(mon_w.wen));
               check("mem_wdata", 64'(o_mem_wdata), 64'(mon_w.data));
            end
         end
         if (o_rd_valid && i_rd_ready) begin
            if (rq.size() == 0) report_fail("rd_unexpected");
            else begin
               mon_r = rq.pop_front();
               check("rd_data", 64'(o_rd_data), 64'(mon_r.data));
               check("rd_last", 64'(o_rd_last), 64'(mon_r.last));
            end
         end
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // Called and returns at posedge+1; handshake sampled at posedge+2.
   task automatic send_req(input bit wr, input logic [8:0] adr, input logic [3:0] len,
                           input logic [3:0] be, output bit ok);
      ok = 1'b0;
      i_req_valid = 1'b1; i_req_wr = wr; i_req_adr = adr; i_req_len = len; i_req_be = be;
      for (int c = 0; c < 3000 && !ok; c++) begin
         #1;
         if (o_req_ready) begin
            ok = 1'b1;
            if (!wr)
               for (int k = 0; k <= int'(len); k++)
                  rq.push_back('{ref_mem[9'(int'(adr) + k)], k == int'(len)});
         end
         @(posedge clk);
         #1;
      end
      i_req_valid = 1'b0;
      if (!ok) report_fail("req_timeout");
   endtask

   task automatic do_write(input logic [8:0] adr, input logic [3:0] len, input logic [3:0] be,
                           input bit seq, input logic [31:0] base, input bit gaps);
      bit ok;
      bit sent;
      logic [31:0] d;
      logic [8:0] a;
      send_req(1'b1, adr, len, be, ok);
      if (ok) begin
         for (int k = 0; k <= int'(len); k++) begin
            d = seq ? base + 32'(k) : $urandom;
            a = 9'(int'(adr) + k);
            sent = 1'b0;
            for (int c = 0; c < 100 && !sent; c++) begin
               i_wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
               i_wr_data = d;
               #1;
               if (i_wr_valid && o_wr_ready) begin
                  sent = 1'b1;
                  wq.push_back('{a, be, d});
                  ref_mem[a] = merge(ref_mem[a], d, be);
               end
               @(posedge clk);
               #1;
            end
            if (!sent) report_fail("wr_beat_timeout");
         end
         i_wr_valid = 1'b0;
      end
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         if (rq.size() == 0 && wq.size() == 0 && !o_busy) done = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (!done) report_fail("drain_timeout");
   endtask

   initial begin
      bit ok;
      int n0;
      int busy_cnt;
      for (int i = 0; i < 512; i++) begin
         mem_arr[i] = $urandom;
         ref_mem[i] = mem_arr[i];
      end
      repeat (3) @(posedge clk);
      #2;
      check("rst_req_ready", 64'(o_req_ready), 64'd1);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_rd_valid", 64'(o_rd_valid), 64'd0);
      check("rst_mem_en", 64'(o_mem_en), 64'd0);
      check("rst_mem_wen", 64'(o_mem_wen), 64'd0);
      check("rst_wr_ready", 64'(o_wr_ready), 64'd0);
      check("rst_mem_adr", 64'(o_mem_adr), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 4-beat write then read with latency check.
      do_write(9'h010, 4'd3, 4'hF, 1'b1, 32'hA0, 1'b0);
      rd_force = 1'b1;
      send_req(1'b0, 9'h010, 4'd3, 4'hF, ok);
      @(negedge clk);
      @(negedge clk);
      check("rd_lat_t1", 64'(o_rd_valid), 64'd0);
      @(negedge clk);
      check("rd_lat_t2", 64'(o_rd_valid), 64'd1);
      @(posedge clk);
      #1;
      drain();

      // Byte-enable merge.
      do_write(9'h020, 4'd0, 4'hF, 1'b1, 32'h12345678, 1'b0);
      do_write(9'h020, 4'd0, 4'b0101, 1'b1, 32'hFFFFFFFF, 1'b0);
      send_req(1'b0, 9'h020, 4'd0, 4'hF, ok);
      drain();

      // 16-beat burst wrapping past 511.
      do_write(9'h1FC, 4'd15, 4'hF, 1'b0, 32'h0, 1'b0);
      send_req(1'b0, 9'h1FC, 4'd15, 4'hF, ok);
      drain();

      // Back-pressure: only two reads issue while i_rd_ready is low.
      rd_force = 1'b0;
      @(posedge clk);
      #1;
      n0 = rd_issues;
      send_req(1'b0, 9'h100, 4'd7, 4'hF, ok);
      repeat (6) begin @(posedge clk); #1; end
      check("stall_issues", 64'(rd_issues - n0), 64'd2);
      rd_force = 1'b1;
      drain();

      // Clear with a concurrent request.
      i_clr = 1'b1;
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_adr = 9'h1FE; i_req_len = 4'd3;
      #1;
      check("clr_req_ready", 64'(o_req_ready), 64'd0);
      for (int i = 0; i < 512; i++) begin
         wq.push_back('{9'(i), 4'hF, 32'h0});
         ref_mem[i] = 32'h0;
      end
      @(posedge clk);
      #1;
      i_clr = 1'b0;
      busy_cnt = 0;
      ok = 1'b0;
      for (int c = 0; c < 700 && !ok; c++) begin
         #1;
         if (o_req_ready) begin
            ok = 1'b1;
            for (int k = 0; k < 4; k++) rq.push_back('{32'h0, k == 3});
         end else if (o_busy) busy_cnt++;
         @(posedge clk);
         #1;
      end
      i_req_valid = 1'b0;
      if (!ok) report_fail("clr_accept_timeout");
      check("clr_busy_cycles", 64'(busy_cnt), 64'd512);
      drain();

      // Reset in the middle of an 8-beat read.
      do_write(9'h040, 4'd7, 4'hF, 1'b1, 32'h5500, 1'b0);
      send_req(1'b0, 9'h040, 4'd7, 4'hF, ok);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      rq.delete();
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("post_rst_rd_valid", 64'(o_rd_valid), 64'd0);
      check("post_rst_busy", 64'(o_busy), 64'd0);
      check("post_rst_req_ready", 64'(o_req_ready), 64'd1);
      #4;
      @(posedge clk);
      #1;
      send_req(1'b0, 9'h040, 4'd7, 4'hF, ok);
      drain();

      // Random traffic with back-pressure; reads overlap the previous drain.
      rd_rand = 1'b1;
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 9) < 6)
            do_write(9'($urandom), 4'($urandom), 4'($urandom_range(1, 15)), 1'b0, 32'h0, 1'b1);
         else
            send_req(1'b0, 9'($urandom), 4'($urandom), 4'hF, ok);
      end
      rd_rand = 1'b0;
      rd_force = 1'b1;
      drain();
      check("wq_left", 64'(wq.size()), 64'd0);
      check("rq_left", 64'(rq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
